ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter; the send path that pairs with the PS/2 receive decoder. It sends command bytes such as 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset) to the keyboard. It takes a byte over a valid/ready handshake and drives the open-drain PS/2 clock and data lines through active-high pull-low enables. It then follows the device-generated clock to shift out the frame and reports ack, error or timeout. The PS/2 receive decoder is held off via rx_inhibit while a transfer is in progress.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_sync_edge.sv | 28 ++
 rtl/ps2_host_tx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types, timing helpers and parity for the PS/2 host transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    XFER,
    WAIT_IDLE
  } ps2_state_t;

  localparam int CNT_W = 19;
  localparam int BIT_W = 4;
  localparam int DEF_SYSTEM_CLOCK = 25_000_000;

  // Split the divide so long timeouts (tens of ms) stay inside 32-bit int range.
  function automatic int cycles_from_us(input int clk_hz, input int us);
    return ((clk_hz / 1000) * us) / 1000;
  endfunction

  localparam int DEF_INHIBIT_CYCLES = cycles_from_us(DEF_SYSTEM_CLOCK, 100);
  localparam int DEF_START_TIMEOUT_CYCLES = cycles_from_us(DEF_SYSTEM_CLOCK, 15000);
  localparam int DEF_PACKET_TIMEOUT_CYCLES = cycles_from_us(DEF_SYSTEM_CLOCK, 2000);

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer with falling-edge detect for one asynchronous PS/2 line.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic line,
  output logic level,
  output logic fall
);

  logic sync_p0, sync_p1, sync_p2;

  // Lines idle high, so reset to 1 to avoid a spurious fall after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      sync_p2 <= 1'b1;
    end else begin
      sync_p0 <= line;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign fall  = sync_p2 & ~sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock-following shift-out and ack check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int SYSTEM_CLOCK          = DEF_SYSTEM_CLOCK,
  parameter int INHIBIT_CYCLES        = cycles_from_us(SYSTEM_CLOCK, 100),
  parameter int START_TIMEOUT_CYCLES  = cycles_from_us(SYSTEM_CLOCK, 15000),
  parameter int PACKET_TIMEOUT_CYCLES = cycles_from_us(SYSTEM_CLOCK, 2000)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] PKT_LIM   = CNT_W'(PACKET_TIMEOUT_CYCLES);

  ps2_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [BIT_W-1:0] bit_idx, bit_idx_n;
  logic [8:0]       frame, frame_n;
  logic             clk_oe_n, data_oe_n, done_n, ack_err_n, timeout_err_n;
  logic             clk_s, clk_fall, data_s, data_fall_unused;

  ps2_sync_edge u_clk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .line    (ps2_clk),
    .level   (clk_s),
    .fall    (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .line    (ps2_data),
    .level   (data_s),
    .fall    (data_fall_unused)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      frame       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      frame       <= frame_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      done        <= done_n;
      ack_err     <= ack_err_n;
      timeout_err <= timeout_err_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    bit_idx_n     = bit_idx;
    frame_n       = frame;
    clk_oe_n      = ps2_clk_oe;
    data_oe_n     = ps2_data_oe;
    done_n        = 1'b0;
    ack_err_n     = 1'b0;
    timeout_err_n = 1'b0;

    case (state)
      IDLE: begin
        if (tx_valid) begin
          state_n   = INHIBIT;
          cnt_n     = '0;
          bit_idx_n = '0;
          frame_n   = {odd_parity(tx_data), tx_data};
          clk_oe_n  = 1'b1;
          data_oe_n = 1'b0;
        end
      end

      INHIBIT: begin
        if (cnt == INH_LAST) begin
          state_n   = REQ;
          cnt_n     = '0;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      REQ: begin
        if (cnt == START_LIM) begin
          state_n       = IDLE;
          cnt_n         = '0;
          clk_oe_n      = 1'b0;
          data_oe_n     = 1'b0;
          timeout_err_n = 1'b1;
        end else if (clk_fall) begin
          // First fall only presents bit 0; the shift starts on the next fall.
          state_n   = XFER;
          cnt_n     = '0;
          bit_idx_n = 4'd1;
          data_oe_n = ~frame[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      XFER: begin
        if (cnt == PKT_LIM) begin
          state_n       = IDLE;
          cnt_n         = '0;
          bit_idx_n     = '0;
          clk_oe_n      = 1'b0;
          data_oe_n     = 1'b0;
          timeout_err_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
          if (clk_fall) begin
            if (bit_idx < 4'd9) begin
              data_oe_n = ~frame[1];
              frame_n   = {1'b0, frame[8:1]};
              bit_idx_n = bit_idx + 1'b1;
            end else if (bit_idx == 4'd9) begin
              data_oe_n = 1'b0;
              bit_idx_n = 4'd10;
            end else begin
              done_n    = ~data_s;
              ack_err_n = data_s;
              data_oe_n = 1'b0;
              state_n   = WAIT_IDLE;
            end
          end
        end
      end

      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          state_n   = IDLE;
          cnt_n     = '0;
          bit_idx_n = '0;
        end else if (cnt == PKT_LIM) begin
          state_n       = IDLE;
          cnt_n         = '0;
          bit_idx_n     = '0;
          clk_oe_n      = 1'b0;
          data_oe_n     = 1'b0;
          timeout_err_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n   = IDLE;
        cnt_n     = '0;
        bit_idx_n = '0;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
      end
    endcase
  end

  assign tx_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign rx_inhibit = busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a clock-generating device model.
module tb_ps2_host_tx;

  localparam int H = 50;  // device clock half-period in clk cycles (scaled down from 10 kHz)

  logic       clk;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       rx_inhibit;
  logic       done;
  logic       ack_err;
  logic       timeout_err;

  logic dev_clk_low;
  logic dev_data_low;
  bit   mon_busy;

  int vectors;
  int miscompares;
  int done_cnt, ack_cnt, to_cnt, busy_viol;

  assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .SYSTEM_CLOCK          (25_000_000),
    .INHIBIT_CYCLES        (2500),
    .START_TIMEOUT_CYCLES  (1000),
    .PACKET_TIMEOUT_CYCLES (2000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .rx_inhibit  (rx_inhibit),
    .done        (done),
    .ack_err     (ack_err),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ack_err) ack_cnt++;
    if (timeout_err) to_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (mon_busy && !(busy && rx_inhibit && !tx_ready)) busy_viol++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (busy && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check(tag, busy, 1'b0);
    tick(5);
  endtask

  // Device side: waits for the inhibit, then clocks n_falls edges, sampling data on each rise.
  task automatic dev_frame(input bit ack, input int n_falls, input bit keep_valid,
                           input logic [7:0] next_data, output logic [10:0] smp,
                           output int inh_len);
    int g;
    smp = '0;
    inh_len = 0;
    g = 0;
    while (!ps2_clk_oe && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("inhibit_start", ps2_clk_oe, 1'b1);
    if (keep_valid) tx_data = next_data;
    else tx_valid = 1'b0;
    mon_busy = 1'b1;
    while (ps2_clk_oe && inh_len < 10000) begin
      inh_len++;
      tick(1);
    end
    tick(20);
    smp[0] = ps2_data;
    for (int i = 1; i <= n_falls; i++) begin
      dev_clk_low = 1'b1;
      tick(H);
      if (i == 11) mon_busy = 1'b0;
      dev_clk_low = 1'b0;
      if (i <= 10) smp[i] = ps2_data;
      if (i == 10 && ack) begin
        tick(10);
        dev_data_low = 1'b1;
        tick(H - 10);
      end else begin
        tick(H);
      end
    end
    if (dev_data_low) begin
      tick(10);
      dev_data_low = 1'b0;
    end
    mon_busy = 1'b0;
  endtask

  initial begin
    logic [10:0] smp, smp2;
    int inh, n, g, d0, a0, t0;

    vectors = 0;
    miscompares = 0;
    done_cnt = 0;
    ack_cnt = 0;
    to_cnt = 0;
    busy_viol = 0;
    mon_busy = 1'b0;
    reset_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_data_oe", ps2_data_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_inhibit", rx_inhibit, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_pulses", {done, ack_err, timeout_err}, 3'b000);
    reset_n = 1'b1;
    tick(5);

    // 0xED with ack
    d0 = done_cnt; a0 = ack_cnt; t0 = to_cnt;
    tx_data = 8'hED;
    tx_valid = 1'b1;
    dev_frame(1'b1, 11, 1'b0, 8'h00, smp, inh);
    check("ed_inhibit_len", inh, 2500);
    check("ed_bits", smp, {1'b1, 1'b1, 8'hED, 1'b0});
    wait_idle("ed_idle");
    check("ed_done", done_cnt - d0, 1);
    check("ed_ack_err", ack_cnt - a0, 0);
    check("ed_timeout", to_cnt - t0, 0);

    // 0x00 with no ack
    d0 = done_cnt; a0 = ack_cnt; t0 = to_cnt;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    dev_frame(1'b0, 11, 1'b0, 8'h00, smp, inh);
    check("nak_parity", smp[9], 1'b1);
    check("nak_bits", smp, {1'b1, 1'b1, 8'h00, 1'b0});
    wait_idle("nak_idle");
    check("nak_ack_err", ack_cnt - a0, 1);
    check("nak_done", done_cnt - d0, 0);

    // Device never clocks: start timeout
    t0 = to_cnt;
    tx_data = 8'h12;
    tx_valid = 1'b1;
    g = 0;
    while (!ps2_clk_oe && g < 100) begin @(negedge clk); g++; end
    tx_valid = 1'b0;
    g = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && g < 4000) begin @(negedge clk); g++; end
    check("st_req_entry", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    n = 0;
    while (!timeout_err && n < 2000) begin @(negedge clk); n++; end
    check("st_cycles", n, 1001);
    check("st_oes", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    tick(3);
    check("st_pulse", to_cnt - t0, 1);
    check("st_busy", busy, 1'b0);

    // Reset after fall 5 of 0x0F, then a clean 0xF4
    tx_data = 8'h0F;
    tx_valid = 1'b1;
    dev_frame(1'b1, 5, 1'b0, 8'h00, smp, inh);
    check("mid_busy", busy, 1'b1);
    check("mid_data_oe", ps2_data_oe, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_oes", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", tx_ready, 1'b1);
    reset_n = 1'b1;
    tick(5);
    d0 = done_cnt;
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    dev_frame(1'b1, 11, 1'b0, 8'h00, smp, inh);
    check("f4_bits", smp, {1'b1, 1'b0, 8'hF4, 1'b0});
    wait_idle("f4_idle");
    check("f4_done", done_cnt - d0, 1);

    // Back-to-back: valid held high, data changes to 0xAA during the first frame
    d0 = done_cnt;
    busy_viol = 0;
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    dev_frame(1'b1, 11, 1'b1, 8'hAA, smp, inh);
    check("b2b_first", smp, {1'b1, 1'b1, 8'hFF, 1'b0});
    check("b2b_first_done", done_cnt - d0, 1);
    dev_frame(1'b1, 11, 1'b0, 8'h00, smp2, inh);
    check("b2b_second", smp2, {1'b1, 1'b1, 8'hAA, 1'b0});
    wait_idle("b2b_idle");
    check("b2b_done", done_cnt - d0, 2);
    check("b2b_busy_held", busy_viol, 0);

    // Device stops after fall 6: packet timeout
    d0 = done_cnt; a0 = ack_cnt; t0 = to_cnt;
    tx_data = 8'h55;
    tx_valid = 1'b1;
    dev_frame(1'b1, 6, 1'b0, 8'h00, smp, inh);
    g = 0;
    while (!timeout_err && g < 3000) begin @(negedge clk); g++; end
    check("pk_timeout", timeout_err, 1'b1);
    check("pk_oes", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    tick(3);
    check("pk_pulse", to_cnt - t0, 1);
    check("pk_no_done", done_cnt - d0, 0);
    check("pk_no_ack_err", ack_cnt - a0, 0);
    check("pk_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
